// File: rtl/naneye_gen_pkg.sv
// naneye_gen_pkg: shared states, encodings and LFSR
// constants for the NanEye stream generator.
package naneye_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FSYNC,
      ST_ROW_DATA,
      ST_ROW_GAP
   } gen_state_e;

   localparam logic [1:0] PAT_CNT   = 2'd0;
   localparam logic [1:0] PAT_CONST = 2'd1;
   localparam logic [1:0] PAT_LFSR  = 2'd2;
   localparam logic [1:0] PAT_CHECK = 2'd3;

   localparam logic [1:0] JM_SYM  = 2'd0;
   localparam logic [1:0] JM_POS  = 2'd1;
   localparam logic [1:0] JM_NEG  = 2'd2;
   localparam logic [1:0] JM_NONE = 2'd3;

   // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // start bit + stop bit around each pixel
   localparam int WORD_OVH = 2;

endpackage

// File: rtl/naneye_lfsr16.sv
// naneye_lfsr16: 16-bit Fibonacci LFSR that steps
// once per cycle while enabled.
module naneye_lfsr16
   import naneye_gen_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [15:0] seed_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // shift left, feedback is the parity of the tapped bits
   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
      end
   end

   // state register, reloads the seed on reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= seed_i;
      else         state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/naneye_stream_gen.sv
// naneye_stream_gen: on-chip Manchester frame source
// with jittered half-bit timing for RX loopback.
module naneye_stream_gen
   import naneye_gen_pkg::*;
#(
   parameter int          D_WIDTH      = 10,
   parameter int          ROWS         = 250,
   parameter int          COLS         = 250,
   parameter int          HALF_CYC     = 4,
   parameter int          JIT          = 0,
   parameter int          FSYNC_HALVES = 6,
   parameter int          ROW_GAP      = 2,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic               SCLOCK,
   input  logic               RESET_N,
   input  logic               ENABLE,
   input  logic [1:0]         PATTERN,
   input  logic [1:0]         JIT_MODE,
   input  logic [D_WIDTH-1:0] CONST_VAL,
   output logic               TX_DATA,
   output logic               BIT_STROBE,
   output logic               LINE_START,
   output logic               FRAME_START,
   output logic               BUSY,
   output logic [15:0]        FRAME_CNT
);

   localparam int WORD = D_WIDTH + WORD_OVH;
   localparam int MAXB = (WORD > ROW_GAP) ? WORD : ROW_GAP;
   localparam int BW   = $clog2(MAXB);
   localparam int HW   = $clog2(FSYNC_HALVES);
   localparam int LW   = $clog2(HALF_CYC + JIT);
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [BW-1:0] WORD_LAST = BW'(WORD - 1);
   localparam logic [BW-1:0] GAP_LAST  = BW'(ROW_GAP - 1);
   localparam logic [HW-1:0] FS_LAST   = HW'(FSYNC_HALVES - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

   gen_state_e          state_q, state_d;
   logic [LW-1:0]       cnt_q, cnt_d;
   logic [HW-1:0]       half_q, half_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [WORD-1:0]     sh_q, sh_d;
   logic [1:0]          pat_q, pat_d;
   logic [D_WIDTH-1:0]  cval_q, cval_d;
   logic [15:0]         fcnt_q, fcnt_d;
   logic                tx_q, tx_d;
   logic                bs_q, bs_d;
   logic                ls_q, ls_d;
   logic                fs_q, fs_d;
   logic                busy_q, busy_d;
   logic                load, go_word, go_row, go_frame;
   logic [15:0]         lfsr;

   naneye_lfsr16 u_lfsr (
      .clk_i   (SCLOCK),
      .rst_ni  (RESET_N),
      .en_i    (load),
      .seed_i  (LFSR_SEED),
      .state_o (lfsr)
   );

   // cycles-minus-one of the next half-period
   function automatic logic [LW-1:0] half_len(
      input logic [7:0] r,
      input logic [1:0] m
   );
      int v;
      int j;
      v = int'({24'd0, r});
      j = 0;
      if (JIT > 0) begin
         case (m)
            JM_SYM:  j = v % (2 * JIT + 1) - JIT;
            JM_POS:  j = v % (JIT + 1);
            JM_NEG:  j = -(v % (JIT + 1));
            default: j = 0;
         endcase
      end
      return LW'(HALF_CYC + j - 1);
   endfunction

   function automatic logic [D_WIDTH-1:0] pixel(
      input logic [1:0]         pat,
      input logic [CW-1:0]      c,
      input logic [RW-1:0]      r,
      input logic [15:0]        fc,
      input logic [D_WIDTH-1:0] cv,
      input logic [15:0]        lf
   );
      logic [D_WIDTH-1:0] p;
      unique case (pat)
         PAT_CNT:   p = D_WIDTH'(c) + D_WIDTH'(r) + D_WIDTH'(fc);
         PAT_CONST: p = cv;
         PAT_LFSR:  p = lf[D_WIDTH-1:0];
         default:   p = (c[0] ^ r[0]) ? '1 : '0;
      endcase
      return p;
   endfunction

   // next-state: advance the half/bit/col/row walk
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      bit_d    = bit_q;
      col_d    = col_q;
      row_d    = row_q;
      sh_d     = sh_q;
      pat_d    = pat_q;
      cval_d   = cval_q;
      fcnt_d   = fcnt_q;
      tx_d     = tx_q;
      bs_d     = 1'b0;
      ls_d     = 1'b0;
      fs_d     = 1'b0;
      load     = 1'b0;
      go_word  = 1'b0;
      go_row   = 1'b0;
      go_frame = 1'b0;
      if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
      unique case (state_q)
         ST_IDLE: go_frame = ENABLE;
         ST_FSYNC: if (cnt_q == '0) begin
            if (half_q == FS_LAST) begin
               row_d  = '0;
               go_row = 1'b1;
            end else begin
               half_d = half_q + HW'(1);
               load   = 1'b1;
            end
         end
         ST_ROW_DATA: if (cnt_q == '0) begin
            if (half_q == '0) begin
               half_d = HW'(1);
               tx_d   = ~sh_q[WORD-1];
               load   = 1'b1;
            end else if (bit_q != WORD_LAST) begin
               half_d = '0;
               bit_d  = bit_q + BW'(1);
               sh_d   = {sh_q[WORD-2:0], 1'b0};
               tx_d   = sh_q[WORD-2];
               bs_d   = 1'b1;
               load   = 1'b1;
            end else if (col_q != COL_LAST) begin
               col_d   = col_q + CW'(1);
               go_word = 1'b1;
            end else begin
               state_d = ST_ROW_GAP;
               half_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b1;
               bs_d    = 1'b1;
               load    = 1'b1;
            end
         end
         ST_ROW_GAP: if (cnt_q == '0) begin
            if (half_q == '0) begin
               half_d = HW'(1);
               tx_d   = 1'b0;
               load   = 1'b1;
            end else if (bit_q != GAP_LAST) begin
               half_d = '0;
               bit_d  = bit_q + BW'(1);
               tx_d   = 1'b1;
               bs_d   = 1'b1;
               load   = 1'b1;
            end else if (row_q != ROW_LAST) begin
               row_d  = row_q + RW'(1);
               go_row = 1'b1;
            end else begin
               fcnt_d = fcnt_q + 16'd1;
               if (ENABLE) begin
                  go_frame = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b0;
               end
            end
         end
      endcase
      if (go_row) begin
         state_d = ST_ROW_DATA;
         col_d   = '0;
         ls_d    = 1'b1;
         go_word = 1'b1;
      end
      if (go_word) begin
         half_d = '0;
         bit_d  = '0;
         sh_d   = {1'b1, pixel(pat_q, col_d, row_d, fcnt_q,
                                cval_q, lfsr), 1'b0};
         tx_d   = 1'b1;
         bs_d   = 1'b1;
         load   = 1'b1;
      end
      if (go_frame) begin
         state_d = ST_FSYNC;
         half_d  = '0;
         tx_d    = 1'b0;
         fs_d    = 1'b1;
         pat_d   = PATTERN;
         cval_d  = CONST_VAL;
         load    = 1'b1;
      end
      if (load) cnt_d = half_len(lfsr[7:0], JIT_MODE);
      busy_d = (state_d != ST_IDLE);
   end

   // registered state and outputs
   always_ff @(posedge SCLOCK) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         bit_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         sh_q    <= '0;
         pat_q   <= '0;
         cval_q  <= '0;
         fcnt_q  <= '0;
         tx_q    <= 1'b0;
         bs_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         bit_q   <= bit_d;
         col_q   <= col_d;
         row_q   <= row_d;
         sh_q    <= sh_d;
         pat_q   <= pat_d;
         cval_q  <= cval_d;
         fcnt_q  <= fcnt_d;
         tx_q    <= tx_d;
         bs_q    <= bs_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
      end
   end

   assign TX_DATA     = tx_q;
   assign BIT_STROBE  = bs_q;
   assign LINE_START  = ls_q;
   assign FRAME_START = fs_q;
   assign BUSY        = busy_q;
   assign FRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_naneye_stream_gen.sv
// tb_naneye_stream_gen: decodes TX_DATA back into words
// and half lengths and checks them against directed values.
module tb_naneye_stream_gen;

   localparam int DW   = 10;
   localparam int ROWS = 2;
   localparam int COLS = 2;
   localparam int HC   = 4;
   localparam int JIT  = 1;
   localparam int FSH  = 6;
   localparam int GAP  = 2;
   localparam int WORD = DW + 2;
   localparam int FLEN = FSH * HC + ROWS * (COLS * WORD + GAP) * 2 * HC;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          SCLOCK    = 1'b0;
   logic          RESET_N   = 1'b0;
   logic          ENABLE    = 1'b0;
   logic [1:0]    PATTERN   = 2'd0;
   logic [1:0]    JIT_MODE  = 2'd3;
   logic [DW-1:0] CONST_VAL = '0;
   logic          TX_DATA;
   logic          BIT_STROBE;
   logic          LINE_START;
   logic          FRAME_START;
   logic          BUSY;
   logic [15:0]   FRAME_CNT;

   always #5 SCLOCK = ~SCLOCK;

   naneye_stream_gen #(
      .D_WIDTH      (DW),
      .ROWS         (ROWS),
      .COLS         (COLS),
      .HALF_CYC     (HC),
      .JIT          (JIT),
      .FSYNC_HALVES (FSH),
      .ROW_GAP      (GAP),
      .LFSR_SEED    (SEED)
   ) dut (
      .SCLOCK      (SCLOCK),
      .RESET_N     (RESET_N),
      .ENABLE      (ENABLE),
      .PATTERN     (PATTERN),
      .JIT_MODE    (JIT_MODE),
      .CONST_VAL   (CONST_VAL),
      .TX_DATA     (TX_DATA),
      .BIT_STROBE  (BIT_STROBE),
      .LINE_START  (LINE_START),
      .FRAME_START (FRAME_START),
      .BUSY        (BUSY),
      .FRAME_CNT   (FRAME_CNT)
   );

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] s,
                                         input int n);
      logic [15:0] v;
      v = s;
      for (int i = 0; i < n; i++)
         v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
      return v;
   endfunction

   // decoder state
   logic            prev_tx = 1'b0;
   logic [WORD-1:0] wsh = '0;
   logic [WORD-1:0] words[$];
   int              flens[$];
   int              hist[16];
   bit              in_bit = 0;
   bit              in_frame = 0;
   int              bt = 0;
   int              mid = 0;
   int              ntr = 0;
   int              pos = 0;
   int              fcyc = 0;
   int              fs_cnt = 0;
   int              nline = 0;
   int              nstrobe = 0;
   int              manch_err = 0;
   int              gap_err = 0;

   task automatic clr();
      words.delete();
      flens.delete();
      fs_cnt = 0;
      nline = 0;
      nstrobe = 0;
      manch_err = 0;
      gap_err = 0;
      foreach (hist[i]) hist[i] = 0;
   endtask

   task automatic step();
      @(posedge SCLOCK);
      #1;
   endtask

   // decoder: samples on the falling edge
   initial begin
      foreach (hist[i]) hist[i] = 0;
      forever begin
         @(negedge SCLOCK);
         if (!RESET_N) begin
            in_bit = 0;
            in_frame = 0;
         end else begin
            if (BIT_STROBE || LINE_START || FRAME_START) nstrobe++;
            if (LINE_START) nline++;
            if (FRAME_START) begin
               fs_cnt++;
               in_bit = 0;
               if (in_frame) flens.push_back(fcyc);
               in_frame = 1;
               fcyc = 1;
            end else if (in_frame) begin
               if (!BUSY) begin
                  flens.push_back(fcyc);
                  in_frame = 0;
                  in_bit = 0;
               end else begin
                  fcyc++;
               end
            end
            if (BIT_STROBE) begin
               if (in_bit) begin
                  if (ntr != 1) begin
                     manch_err++;
                  end else begin
                     hist[(mid > 15) ? 15 : mid]++;
                     hist[(bt - mid > 15) ? 15 : bt - mid]++;
                  end
               end
               in_bit = 1;
               bt = 1;
               ntr = 0;
               mid = 0;
               if (LINE_START) pos = 0;
               if (pos < COLS * WORD) begin
                  wsh = {wsh[WORD-2:0], TX_DATA};
                  if (pos % WORD == WORD - 1) words.push_back(wsh);
               end else if (!TX_DATA) begin
                  gap_err++;
               end
               pos++;
            end else if (in_bit) begin
               if (TX_DATA != prev_tx) begin
                  ntr++;
                  mid = bt;
               end
               bt++;
            end
            prev_tx = TX_DATA;
         end
      end
   end

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (BUSY && n < budget) begin
         step();
         n++;
      end
      chk(tag, int'(BUSY), 0);
      step();
      step();
   endtask

   task automatic wait_fs(input string tag, input int target,
                          input int budget);
      int n;
      n = 0;
      while (fs_cnt < target && n < budget) begin
         step();
         n++;
      end
      chk(tag, int'(fs_cnt >= target), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WORD-1:0] e;
      logic [15:0]     lf;
      int              lo;
      int              hi;
      int              bad;
      int              m;
      int              offs[4];
      offs = '{6, 30, 58, 82};

      // reset and idle
      repeat (5) step();
      chk("rst_tx", int'(TX_DATA), 0);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_fcnt", int'(FRAME_CNT), 0);
      RESET_N = 1'b1;
      clr();
      repeat (100) step();
      chk("idle_strobes", nstrobe, 0);

      // constant pattern, single frame
      PATTERN = 2'd1;
      CONST_VAL = 10'h2A5;
      JIT_MODE = 2'd3;
      clr();
      ENABLE = 1'b1;
      step();
      chk("lat_fstart", int'(FRAME_START), 1);
      chk("lat_busy", int'(BUSY), 1);
      chk("lat_tx", int'(TX_DATA), 0);
      ENABLE = 1'b0;
      wait_idle("t2_busy_fall", 2000);
      chk("t2_nframes", flens.size(), 1);
      if (flens.size() > 0) chk("t2_len", flens[0], FLEN);
      chk("t2_nwords", words.size(), 4);
      foreach (words[i])
         chk($sformatf("t2_word%0d", i), int'(words[i]),
             int'({1'b1, 10'h2A5, 1'b0}));
      chk("t2_fcnt", int'(FRAME_CNT), 1);
      chk("t2_lines", nline, ROWS);
      chk("t2_manch", manch_err, 0);
      chk("t2_gap", gap_err, 0);

      // counter pattern, two back-to-back frames
      RESET_N = 1'b0;
      step();
      RESET_N = 1'b1;
      clr();
      PATTERN = 2'd0;
      ENABLE = 1'b1;
      wait_fs("t3_second_fs", 2, 2000);
      ENABLE = 1'b0;
      wait_idle("t3_busy_fall", 2000);
      chk("t3_nframes", flens.size(), 2);
      foreach (flens[i]) chk($sformatf("t3_len%0d", i), flens[i], FLEN);
      chk("t3_nwords", words.size(), 8);
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
               e = {1'b1, DW'(f + r + c), 1'b0};
               if (f * 4 + r * 2 + c < words.size())
                  chk($sformatf("t3_f%0dr%0dc%0d", f, r, c),
                      int'(words[f * 4 + r * 2 + c]), int'(e));
            end
      chk("t3_fcnt", int'(FRAME_CNT), 2);

      // jitter distributions, continuous framing
      PATTERN = 2'd2;
      clr();
      ENABLE = 1'b1;
      for (int mi = 0; mi < 3; mi++) begin
         m = (mi == 0) ? 1 : (mi == 1) ? 2 : 0;
         JIT_MODE = 2'(m);
         repeat (20) step();
         clr();
         repeat (10000) step();
         lo = (m == 1) ? HC : HC - JIT;
         hi = (m == 2) ? HC : HC + JIT;
         bad = 0;
         for (int v = 0; v < 16; v++)
            if (v < lo || v > hi) bad += hist[v];
         chk($sformatf("jit_m%0d_out_of_range", m), bad, 0);
         for (int v = lo; v <= hi; v++)
            chk($sformatf("jit_m%0d_seen_%0d", m, v),
                int'(hist[v] > 0), 1);
         chk($sformatf("jit_m%0d_manch", m), manch_err, 0);
      end
      ENABLE = 1'b0;
      wait_idle("t4_busy_fall", 2000);

      // drop ENABLE inside row 0, checker pattern
      RESET_N = 1'b0;
      step();
      RESET_N = 1'b1;
      clr();
      PATTERN = 2'd3;
      JIT_MODE = 2'd3;
      ENABLE = 1'b1;
      wait_fs("t5_fs", 1, 50);
      repeat (60) step();
      ENABLE = 1'b0;
      wait_idle("t5_busy_fall", 2000);
      chk("t5_nframes", flens.size(), 1);
      if (flens.size() > 0) chk("t5_len", flens[0], FLEN);
      chk("t5_tx_low", int'(TX_DATA), 0);
      for (int k = 0; k < 4; k++) begin
         e = {1'b1, (((k >> 1) ^ k) & 1) != 0 ? {DW{1'b1}} : {DW{1'b0}},
              1'b0};
         if (k < words.size())
            chk($sformatf("t5_word%0d", k), int'(words[k]), int'(e));
      end
      repeat (50) step();
      chk("t5_no_restart", fs_cnt, 1);

      // reset pulse mid-word, then LFSR restart from seed
      PATTERN = 2'd2;
      clr();
      ENABLE = 1'b1;
      step();
      ENABLE = 1'b0;
      repeat (150) step();
      RESET_N = 1'b0;
      step();
      chk("t6_rst_tx", int'(TX_DATA), 0);
      chk("t6_rst_busy", int'(BUSY), 0);
      chk("t6_rst_fcnt", int'(FRAME_CNT), 0);
      RESET_N = 1'b1;
      step();
      clr();
      ENABLE = 1'b1;
      step();
      ENABLE = 1'b0;
      wait_idle("t6_busy_fall", 2000);
      chk("t6_nwords", words.size(), 4);
      for (int k = 0; k < 4; k++) begin
         lf = lstep(SEED, offs[k]);
         e = {1'b1, lf[DW-1:0], 1'b0};
         if (k < words.size())
            chk($sformatf("t6_lfsr_word%0d", k), int'(words[k]), int'(e));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
